// File: rtl/philv_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, port ids and
// the favour reset value.
package philv_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic ARB_PORT_IF = 1'b0;
  localparam logic ARB_PORT_D  = 1'b1;

  localparam logic FAVOUR_RST = ARB_PORT_IF;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/philv_mem_arbiter_rr_arbiter2.sv
// Two-request round-robin picker; owns the favour flip-flop, which points at
// the port that wins the next tie.
module rr_arbiter2
  import philv_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant,
  output logic       any
);

  logic favour;

  always_ff @(posedge clk) begin
    if (rst) begin
      favour <= FAVOUR_RST;
    end else if (update) begin
      favour <= other_port(served);
    end
  end

  // req[0] is fetch, req[1] is data; a tie goes to the favoured port.
  always_comb begin
    any   = |req;
    grant = favour;
    if (req == 2'b01) begin
      grant = ARB_PORT_IF;
    end else if (req == 2'b10) begin
      grant = ARB_PORT_D;
    end
  end

endmodule

// File: rtl/philv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store: IDLE -> ISSUE -> WAIT -> DONE per access, round-robin on ties.
module philv_mem_arbiter
  import philv_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          port_q;
  logic          we_q;
  logic          grant;
  logic          any;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({d_req, if_req}),
    .update (state == ST_DONE),
    .served (port_q),
    .grant  (grant),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      port_q    <= ARB_PORT_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            // Request fields are captured straight into the memory-side
            // registers; later changes on the requester ports are ignored.
            port_q    <= grant;
            we_q      <= (grant == ARB_PORT_D) && d_we;
            mem_addr  <= (grant == ARB_PORT_D) ? d_addr : if_addr;
            mem_wdata <= (grant == ARB_PORT_D) ? d_wdata : '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CW'(RD_LATENCY);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (!we_q) begin
              if (port_q == ARB_PORT_IF) begin
                if_rdata <= mem_rdata;
              end else begin
                d_rdata <= mem_rdata;
              end
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en = (state == ST_ISSUE);
  assign mem_we = (state == ST_ISSUE) && we_q;
  assign if_ack = (state == ST_DONE) && (port_q == ARB_PORT_IF);
  assign d_ack  = (state == ST_DONE) && (port_q == ARB_PORT_D);
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// Directed bench for philv_mem_arbiter: a vector table of single-port
// transactions plus hand-written contention, latency and reset sequences.
module tb_philv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        if_req3 = 1'b0;
  logic [31:0] if_addr3 = '0;
  logic        if_ack3;
  logic [31:0] if_rdata3;
  logic        d_req3 = 1'b0;
  logic        d_we3 = 1'b0;
  logic [31:0] d_addr3 = '0;
  logic [31:0] d_wdata3 = '0;
  logic        d_ack3;
  logic [31:0] d_rdata3;
  logic        mem_en3;
  logic        mem_we3;
  logic [31:0] mem_addr3;
  logic [31:0] mem_wdata3;
  logic [31:0] mem_rdata3 = '0;
  logic        busy3;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  philv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  philv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // One-cycle-latency memory; data is only valid in the cycle after issue.
  logic [31:0] mem [0:255];
  logic        rd_valid = 1'b0;
  logic [31:0] rd_q = '0;

  always @(posedge clk) begin
    rd_valid <= mem_en && !mem_we;
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        rd_q <= mem[mem_addr[9:2]];
    end
  end

  assign mem_rdata = rd_valid ? rd_q : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_if,
                        input logic [31:0] exp_d);
    int   ack_k;
    int   en_cnt;
    logic wrong;
    @(negedge clk);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    ack_k = -1; en_cnt = 0; wrong = 1'b0;
    for (int k = 1; k <= 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("issue_en", {31'd0, mem_en}, 32'd1);
        check("issue_we", {31'd0, mem_we}, {31'd0, we});
        check("issue_addr", mem_addr, addr);
        check("issue_wdata", mem_wdata, wdata);
      end
      if (k == 2) begin
        // Perturb request fields after IDLE; the access must not notice.
        if_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
      end
      if (mem_en) en_cnt++;
      if ((port ? if_ack : d_ack)) wrong = 1'b1;
      if ((port ? d_ack : if_ack)) begin
        ack_k = k;
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("ack_latency", 32'(ack_k), 32'd3);
    check("mem_en_count", 32'(en_cnt), 32'd1);
    check("wrong_port_ack", {31'd0, wrong}, 32'd0);
    check("if_rdata", if_rdata, exp_if);
    check("d_rdata", d_rdata, exp_d);
  endtask

  initial begin
    logic ack_port [4];
    int   ack_cyc [4];
    int   n;
    logic both;
    int   en3, ack3, if_k, d_k;
    logic stray;

    vecs[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h040, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h040, 32'h0,        32'hDEADBEEF, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h040, 32'h0,        32'h12345678, 32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_busy3", {31'd0, busy3}, 32'd0);

    // RD_LATENCY=3 data read: capture at cycle 4, ack at cycle 5
    @(negedge clk);
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h80; mem_rdata3 = 32'h5000_0000;
    en3 = 0; ack3 = -1;
    for (int k = 1; k <= 15 && ack3 < 0; k++) begin
      @(negedge clk);
      mem_rdata3 = (k == 4) ? 32'h0BAD_CAFE : 32'h5000_0000 + 32'(k);
      if (k == 1) check("l3_issue_addr", mem_addr3, 32'h80);
      if (mem_en3) en3++;
      if (d_ack3) begin
        ack3 = k;
        d_req3 = 1'b0;
      end
    end
    d_req3 = 1'b0;
    check("l3_ack_latency", 32'(ack3), 32'd5);
    check("l3_mem_en_count", 32'(en3), 32'd1);
    check("l3_d_rdata", d_rdata3, 32'h0BAD_CAFE);
    check("l3_if_rdata", if_rdata3, 32'd0);

    // Single-port transaction table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_if, vecs[i].exp_d);
    end

    // Continuous contention right after reset: IF, D, IF, D every 4 cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h040;
    n = 0; both = 1'b0;
    for (int k = 1; k <= 30 && n < 4; k++) begin
      @(negedge clk);
      if (if_ack && d_ack) both = 1'b1;
      else if (if_ack || d_ack) begin
        ack_port[n] = d_ack;
        ack_cyc[n] = k;
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("cont_ack_count", 32'(n), 32'd4);
    check("cont_both_ack", {31'd0, both}, 32'd0);
    for (int i = 0; i < n; i++) begin
      check("cont_grant_port", {31'd0, ack_port[i]}, 32'(i % 2));
      check("cont_ack_cycle", 32'(ack_cyc[i]), 32'(3 + 4 * i));
    end
    check("cont_if_rdata", if_rdata, 32'hDEADBEEF);
    check("cont_d_rdata", d_rdata, 32'h12345678);

    // Data request arriving during a fetch WAIT
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    if_k = -1; d_k = -1;
    for (int k = 1; k <= 20 && d_k < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h040;
      end
      if (k == 4) check("mid_busy_idle", {31'd0, busy}, 32'd0);
      if (k == 5) check("mid_busy_issue", {31'd0, busy}, 32'd1);
      if (if_ack) begin if_k = k; if_req = 1'b0; end
      if (d_ack) begin d_k = k; d_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("mid_if_ack_cycle", 32'(if_k), 32'd3);
    check("mid_d_ack_cycle", 32'(d_k), 32'd7);
    check("mid_if_rdata", if_rdata, 32'hCAFEF00D);
    check("mid_d_rdata", d_rdata, 32'h12345678);

    // One-cycle reset during WAIT, then the request is re-presented
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    check("rw_issue_en", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    check("rw_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    check("rw_if_ack", {31'd0, if_ack}, 32'd0);
    check("rw_d_ack", {31'd0, d_ack}, 32'd0);
    check("rw_mem_en", {31'd0, mem_en}, 32'd0);
    check("rw_mem_we", {31'd0, mem_we}, 32'd0);
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_mem_wdata", mem_wdata, 32'd0);
    check("rw_if_rdata", if_rdata, 32'd0);
    check("rw_d_rdata", d_rdata, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_ack || d_ack || busy) stray = 1'b1;
    end
    check("rw_no_stray_ack", {31'd0, stray}, 32'd0);
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
